// File: rtl/mc14500_pkg.sv
// Shared types for the MC14500B program-flow blocks.
// Sequencer states and the default ROM address width.
package mc14500_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    HALT
  } seq_state_t;

  typedef logic [ADDR_W-1:0] pc_t;

endpackage

// File: rtl/return_stack.sv
// Small LIFO of return addresses for the program sequencer.
// Simultaneous push and pop is never issued by the sequencer.
module return_stack
  import mc14500_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       cnt;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_idx = cnt[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (AW+1)'(1);
    end
  end

  // Storage needs no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// MC14500B program counter and flow control: call/return via
// JMP/RTN, halt on FLGF, hold while the reset module asks.
module program_sequencer
  import mc14500_pkg::*;
#(
  parameter int ADDR_W      = mc14500_pkg::ADDR_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_reset,
  input  logic              step,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flg0,
  input  logic              flgf,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              halted,
  output logic              flag0_pulse,
  output logic              stack_ovf,
  output logic              stack_unf
);

  seq_state_t state;

  logic              clr;
  logic              run_step;
  logic              do_jmp;
  logic              do_rtn;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] pc_inc;

  assign clr      = reset | pc_reset;
  assign run_step = !clr && (state == RUN) && step;
  // jmp takes priority, so rtn only counts when jmp is low
  assign do_jmp   = run_step && jmp;
  assign do_rtn   = run_step && rtn && !jmp;
  assign push     = do_jmp && !full;
  assign pop      = do_rtn && !empty;
  assign pc_inc   = pc + ADDR_W'(1);

  return_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      pc          <= '0;
      fetch_en    <= 1'b0;
      halted      <= 1'b0;
      flag0_pulse <= 1'b0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else if (pc_reset) begin
      state       <= HOLD;
      pc          <= '0;
      fetch_en    <= 1'b0;
      halted      <= 1'b0;
      flag0_pulse <= 1'b0;
    end else begin
      flag0_pulse <= 1'b0;
      unique case (state)
        HOLD: begin
          state    <= RUN;
          fetch_en <= 1'b1;
        end
        RUN: begin
          if (step) begin
            unique case (1'b1)
              do_jmp: begin
                pc <= jump_target;
                if (full) stack_ovf <= 1'b1;
              end
              do_rtn: begin
                if (empty) begin
                  pc        <= pc_inc;
                  stack_unf <= 1'b1;
                end else begin
                  pc <= top;
                end
              end
              default: pc <= pc_inc;
            endcase
            flag0_pulse <= flg0;
            if (flgf) begin
              state    <= HALT;
              fetch_en <= 1'b0;
              halted   <= 1'b1;
            end
          end
        end
        HALT: begin
          if (resume) begin
            state    <= RUN;
            fetch_en <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomised and directed bench for program_sequencer against
// a queue-based behavioural model of the flow rules.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset, pc_reset, step, jmp, rtn, flg0, flgf, resume;
  logic [7:0] jump_target;
  logic [7:0] pc;
  logic       fetch_en, halted, flag0_pulse, stack_ovf, stack_unf;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_pc;
  logic       m_fetch, m_halted, m_pulse, m_ovf, m_unf;
  logic [7:0] m_stack[$];

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_reset    (pc_reset),
    .step        (step),
    .jmp         (jmp),
    .rtn         (rtn),
    .flg0        (flg0),
    .flgf        (flgf),
    .jump_target (jump_target),
    .resume      (resume),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .halted      (halted),
    .flag0_pulse (flag0_pulse),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic cyc(input logic s, input logic j, input logic r,
                     input logic f0, input logic ff,
                     input logic [7:0] tgt, input logic res,
                     input logic pr, input logic rst);
    reset = rst; pc_reset = pr; step = s; jmp = j; rtn = r;
    flg0 = f0; flgf = ff; jump_target = tgt; resume = res;
    if (rst || pr) begin
      m_pc = 8'h00; m_stack.delete(); m_pulse = 1'b0;
      m_fetch = 1'b0; m_halted = 1'b0;
      if (rst) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      m_pulse = 1'b0;
      if (!m_fetch && !m_halted) begin
        m_fetch = 1'b1;
      end else if (m_halted) begin
        if (res) begin m_fetch = 1'b1; m_halted = 1'b0; end
      end else if (s) begin
        if (j) begin
          if (m_stack.size() < 4) m_stack.push_back(m_pc + 8'd1);
          else m_ovf = 1'b1;
          m_pc = tgt;
        end else if (r) begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin m_pc = m_pc + 8'd1; m_unf = 1'b1; end
        end else begin
          m_pc = m_pc + 8'd1;
        end
        m_pulse = f0;
        if (ff) begin m_halted = 1'b1; m_fetch = 1'b0; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic stepj(input logic [7:0] tgt);
    cyc(1, 1, 0, 0, 0, tgt, 0, 0, 0);
  endtask

  task automatic go_run();
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    idle();
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    total++;
    if ({pc, fetch_en, halted, flag0_pulse, stack_ovf, stack_unf}
        !== {8'h00, 5'b0}) begin
      bad++;
      $display("FAIL reset_state got pc=%h fe=%b h=%b p=%b o=%b u=%b want all 0",
               pc, fetch_en, halted, flag0_pulse, stack_ovf, stack_unf);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 0, 1, 0);
      total++;
      if (pc !== 8'h00 || fetch_en !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d got pc=%h fe=%b want pc=00 fe=0", i, pc, fetch_en);
      end
    end
    // step in HOLD is ignored
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    total++;
    if (fetch_en !== 1'b1 || pc !== 8'h00) begin
      bad++;
      $display("FAIL hold_exit got fe=%b pc=%h want fe=1 pc=00", fetch_en, pc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want [3];
    want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h01;
    go_run();
    stepj(8'hFE);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      total++;
      if (pc !== want[i]) begin
        bad++;
        $display("FAIL wrap_%0d got pc=%h want %h", i, pc, want[i]);
      end
    end
  endtask

  task automatic test_call_return();
    go_run();
    stepj(8'h10);
    stepj(8'h40);
    total++;
    if (pc !== 8'h40) begin
      bad++; $display("FAIL call got pc=%h want 40", pc);
    end
    idle();
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    total++;
    if (pc !== 8'h42) begin
      bad++; $display("FAIL call_steps got pc=%h want 42", pc);
    end
    cyc(1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    total++;
    if (pc !== 8'h11) begin
      bad++; $display("FAIL return got pc=%h want 11", pc);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] pops [5];
    pops[0] = 8'hB1; pops[1] = 8'hA1; pops[2] = 8'h91;
    pops[3] = 8'h01; pops[4] = 8'h02;
    go_run();
    stepj(8'h90); stepj(8'hA0); stepj(8'hB0); stepj(8'hC0);
    total++;
    if (stack_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_early got %b want 0", stack_ovf);
    end
    stepj(8'hD0);
    total++;
    if (pc !== 8'hD0 || stack_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf got pc=%h ovf=%b want D0 1", pc, stack_ovf);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
      total++;
      if (pc !== pops[i] || stack_unf !== (i == 4)) begin
        bad++;
        $display("FAIL pop_%0d got pc=%h unf=%b want %h %b",
                 i, pc, stack_unf, pops[i], i == 4);
      end
    end
  endtask

  task automatic test_halt_resume();
    go_run();
    stepj(8'h20);
    cyc(1, 1, 0, 1, 1, 8'h30, 0, 0, 0);
    total++;
    if ({pc, halted, fetch_en, flag0_pulse} !== {8'h30, 3'b101}) begin
      bad++;
      $display("FAIL halt got pc=%h h=%b fe=%b p=%b want 30 1 0 1",
               pc, halted, fetch_en, flag0_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, i == 1, i == 2, 1, 0, 8'h77, 0, 0, 0);
      total++;
      if (pc !== 8'h30 || halted !== 1'b1 || flag0_pulse !== 1'b0) begin
        bad++;
        $display("FAIL halted_%0d got pc=%h h=%b p=%b want 30 1 0",
                 i, pc, halted, flag0_pulse);
      end
    end
    cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0);
    total++;
    if (fetch_en !== 1'b1 || halted !== 1'b0) begin
      bad++;
      $display("FAIL resume got fe=%b h=%b want 1 0", fetch_en, halted);
    end
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    total++;
    if (pc !== 8'h31) begin
      bad++; $display("FAIL after_resume got pc=%h want 31", pc);
    end
  endtask

  task automatic test_pc_reset_mid();
    go_run();
    for (int i = 0; i < 5; i++) stepj(8'h50 + 8'(i));
    cyc(1, 1, 0, 1, 0, 8'h99, 0, 1, 0);
    total++;
    if ({pc, fetch_en, flag0_pulse, stack_ovf} !== {8'h00, 3'b001}) begin
      bad++;
      $display("FAIL pc_reset got pc=%h fe=%b p=%b ovf=%b want 00 0 0 1",
               pc, fetch_en, flag0_pulse, stack_ovf);
    end
    idle();
    cyc(1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    total++;
    if (pc !== 8'h01 || stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin
      bad++;
      $display("FAIL stack_cleared got pc=%h unf=%b ovf=%b want 01 1 1",
               pc, stack_unf, stack_ovf);
    end
  endtask

  task automatic test_random();
    go_run();
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, 8'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 150) == 0);
      total++;
      if ({pc, fetch_en, halted, flag0_pulse, stack_ovf, stack_unf} !==
          {m_pc, m_fetch, m_halted, m_pulse, m_ovf, m_unf}) begin
        bad++;
        $display("FAIL random_%0d got %h/%b%b%b%b%b want %h/%b%b%b%b%b", n,
                 pc, fetch_en, halted, flag0_pulse, stack_ovf, stack_unf,
                 m_pc, m_fetch, m_halted, m_pulse, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    m_pc = 8'h00; m_fetch = 1'b0; m_halted = 1'b0;
    m_pulse = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_wrap();
    test_call_return();
    test_overflow_underflow();
    test_halt_resume();
    test_pc_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
